// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults for the scoreboarded register file
package reg_file_sb_pkg;
  localparam int WORD_LEN_DEF = 32;
  localparam int ADDR_LEN_DEF = 4;
  localparam int ZERO_REG     = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write flags with issue/writeback/flush
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issueEn,
  input  logic [ADDR_LEN-1:0] issueDest,
  input  logic                writeEn,
  input  logic [ADDR_LEN-1:0] dest,
  input  logic                flush,
  input  logic [ADDR_LEN-1:0] src1,
  input  logic [ADDR_LEN-1:0] src2,
  output logic                busy1,
  output logic                busy2,
  output logic                anyBusy
);
  localparam int DEPTH = 2**ADDR_LEN;
  localparam logic [ADDR_LEN-1:0] ZERO = ADDR_LEN'(ZERO_REG);
  logic [DEPTH-1:0] pending_q, pending_d;
  logic             wb1, wb2;
  // issue is applied after the writeback clear so a new producer wins
  always_comb begin
    pending_d = pending_q;
    if (writeEn) pending_d[dest] = 1'b0;
    if (issueEn) pending_d[issueDest] = 1'b1;
    if (flush) pending_d = '0;
    pending_d[ZERO] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else pending_q <= pending_d;
  end
  assign wb1     = (BYPASS != 0) && writeEn && dest == src1 && src1 != ZERO;
  assign wb2     = (BYPASS != 0) && writeEn && dest == src2 && src2 != ZERO;
  assign busy1   = pending_q[src1] & ~wb1;
  assign busy2   = pending_q[src2] & ~wb2;
  assign anyBusy = |pending_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read one-write register file with write bypass and scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] src1,
  input  logic [ADDR_LEN-1:0] src2,
  output logic [WORD_LEN-1:0] reg1,
  output logic [WORD_LEN-1:0] reg2,
  output logic                busy1,
  output logic                busy2,
  input  logic                issueEn,
  input  logic [ADDR_LEN-1:0] issueDest,
  input  logic                writeEn,
  input  logic [ADDR_LEN-1:0] dest,
  input  logic [WORD_LEN-1:0] writeVal,
  input  logic                flush,
  output logic                anyBusy
);
  localparam int DEPTH = 2**ADDR_LEN;
  localparam logic [ADDR_LEN-1:0] ZERO = ADDR_LEN'(ZERO_REG);
  logic [WORD_LEN-1:0] regs_q [DEPTH];
  logic                fwd1, fwd2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    else if (writeEn && dest != ZERO) regs_q[dest] <= writeVal;
  end
  assign fwd1 = (BYPASS != 0) && writeEn && dest == src1 && src1 != ZERO;
  assign fwd2 = (BYPASS != 0) && writeEn && dest == src2 && src2 != ZERO;
  // forwarding is gated by reset so reads stay 0 while reset is held
  assign reg1 = !rst ? '0 : fwd1 ? writeVal : regs_q[src1];
  assign reg2 = !rst ? '0 : fwd2 ? writeVal : regs_q[src2];
  reg_scoreboard #(.ADDR_LEN(ADDR_LEN), .BYPASS(BYPASS)) u_sb (
    .clk(clk),
    .rst(rst),
    .issueEn(issueEn),
    .issueDest(issueDest),
    .writeEn(writeEn),
    .dest(dest),
    .flush(flush),
    .src1(src1),
    .src2(src2),
    .busy1(busy1),
    .busy2(busy2),
    .anyBusy(anyBusy)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors checked by a queue-based scoreboard on both bypass modes
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2, issueDest, dest;
  logic        issueEn, writeEn, flush;
  logic [31:0] writeVal;
  logic [31:0] b_r1, b_r2, n_r1, n_r2;
  logic        b_b1, b_b2, b_any, n_b1, n_b2, n_any;
  int          checks = 0;
  int          failures = 0;
  typedef struct {
    string       n;
    logic [31:0] r1, r2;
    logic        b1, b2, any;
    logic [31:0] nr1;
    logic        nb1;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_file_sb #(.WORD_LEN(32), .ADDR_LEN(4), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(b_r1), .reg2(b_r2),
    .busy1(b_b1), .busy2(b_b2), .issueEn(issueEn), .issueDest(issueDest),
    .writeEn(writeEn), .dest(dest), .writeVal(writeVal), .flush(flush), .anyBusy(b_any)
  );
  reg_file_sb #(.WORD_LEN(32), .ADDR_LEN(4), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .reg1(n_r1), .reg2(n_r2),
    .busy1(n_b1), .busy2(n_b2), .issueEn(issueEn), .issueDest(issueDest),
    .writeEn(writeEn), .dest(dest), .writeVal(writeVal), .flush(flush), .anyBusy(n_any)
  );

  task automatic chk(string n, string f, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h want=%h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.n, "reg1", b_r1, e.r1);
      chk(e.n, "reg2", b_r2, e.r2);
      chk(e.n, "busy1", {31'd0, b_b1}, {31'd0, e.b1});
      chk(e.n, "busy2", {31'd0, b_b2}, {31'd0, e.b2});
      chk(e.n, "anyBusy", {31'd0, b_any}, {31'd0, e.any});
      chk(e.n, "nb_reg1", n_r1, e.nr1);
      chk(e.n, "nb_busy1", {31'd0, n_b1}, {31'd0, e.nb1});
      chk(e.n, "nb_anyBusy", {31'd0, n_any}, {31'd0, e.any});
    end
  end

  task automatic clr();
    src1 = 0; src2 = 0; issueEn = 0; issueDest = 0;
    writeEn = 0; dest = 0; writeVal = 0; flush = 0;
  endtask

  task automatic put(string n, logic [31:0] r1, logic [31:0] r2, logic b1, logic b2,
                     logic any, logic [31:0] nr1, logic nb1);
    exp_t e;
    e.n = n; e.r1 = r1; e.r2 = r2; e.b1 = b1; e.b2 = b2; e.any = any;
    e.nr1 = nr1; e.nb1 = nb1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    @(posedge clk);
    #1;
    // writes, issues and forwarding all suppressed under reset
    writeEn = 1; dest = 5; writeVal = 32'h11111111; src1 = 5; issueEn = 1; issueDest = 5;
    put("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    clr(); rst = 1'b1;
    writeEn = 1; dest = 5; writeVal = 32'hDEADBEEF; src1 = 5;
    put("first_wr", 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    clr(); issueEn = 1; issueDest = 5; src1 = 5;
    put("issue5", 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    clr(); src1 = 5;
    put("busy5", 32'hDEADBEEF, 0, 1, 0, 1, 32'hDEADBEEF, 1);
    // asynchronous reset asserted between edges
    clr(); rst = 1'b0; src1 = 5;
    put("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    clr(); rst = 1'b1;
    writeEn = 1; dest = 0; writeVal = 32'h1234; issueEn = 1; issueDest = 0; src1 = 0; src2 = 5;
    put("zero_wr", 0, 0, 0, 0, 0, 0, 0);
    clr(); src1 = 0; src2 = 5;
    put("zero_next", 0, 0, 0, 0, 0, 0, 0);
    clr(); writeEn = 1; dest = 3; writeVal = 32'h0BADF00D;
    put("pre_wr3", 0, 0, 0, 0, 0, 0, 0);
    clr(); writeEn = 1; dest = 3; writeVal = 32'hA5A5A5A5; src1 = 3;
    put("bypass_same", 32'hA5A5A5A5, 0, 0, 0, 0, 32'h0BADF00D, 0);
    clr(); src1 = 3;
    put("bypass_next", 32'hA5A5A5A5, 0, 0, 0, 0, 32'hA5A5A5A5, 0);
    clr(); issueEn = 1; issueDest = 7; src1 = 3; src2 = 7;
    put("issue7", 32'hA5A5A5A5, 0, 0, 0, 0, 32'hA5A5A5A5, 0);
    clr(); src1 = 7; src2 = 7;
    put("busy7", 0, 0, 1, 1, 1, 0, 1);
    clr(); writeEn = 1; dest = 7; writeVal = 32'h42; src1 = 7; src2 = 7;
    put("wb7", 32'h42, 32'h42, 0, 0, 1, 0, 1);
    clr(); src1 = 7; src2 = 7;
    put("after_wb7", 32'h42, 32'h42, 0, 0, 0, 32'h42, 0);
    clr(); issueEn = 1; issueDest = 4; writeEn = 1; dest = 4; writeVal = 32'hCAFE0004; src1 = 4;
    put("collide4", 32'hCAFE0004, 0, 0, 0, 0, 0, 0);
    clr(); src1 = 4;
    put("collide_next", 32'hCAFE0004, 0, 1, 0, 1, 32'hCAFE0004, 1);
    clr(); issueEn = 1; issueDest = 2; src1 = 2;
    put("issue2", 0, 0, 0, 0, 1, 0, 0);
    clr(); issueEn = 1; issueDest = 9; src1 = 2;
    put("issue9", 0, 0, 1, 0, 1, 0, 1);
    clr(); issueEn = 1; issueDest = 12; src1 = 9; src2 = 12;
    put("issue12", 0, 0, 1, 0, 1, 0, 1);
    // flush drops the concurrent issue of r6 but keeps the data write to r12
    clr(); flush = 1; issueEn = 1; issueDest = 6; writeEn = 1; dest = 12; writeVal = 32'h12121212;
    src1 = 6; src2 = 12;
    put("flush", 0, 32'h12121212, 0, 0, 1, 0, 0);
    clr(); src1 = 6; src2 = 12;
    put("post_flush", 0, 32'h12121212, 0, 0, 0, 0, 0);
    clr(); writeEn = 1; dest = 9; writeVal = 32'h99; src1 = 9;
    put("wb_nopend", 32'h99, 0, 0, 0, 0, 0, 0);
    clr(); src1 = 9;
    put("wb_nopend_next", 32'h99, 0, 0, 0, 0, 32'h99, 0);
    clr();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter WORD_LEN, default 32, data word width in bits.
REQ-002 Parameter ADDR_LEN, default 4, register address width; DEPTH = 2**ADDR_LEN registers.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 src1, src2  input  ADDR_LEN each  read addresses.
REQ-007 reg1, reg2  output  WORD_LEN each  read data for src1/src2.
REQ-008 busy1, busy2  output  1 each  pending-write flag for src1/src2.
REQ-009 issueEn  input  1  marks a new in-flight producer of issueDest.
REQ-010 issueDest  input  ADDR_LEN  destination register being issued.
REQ-011 writeEn  input  1  writeback strobe.
REQ-012 dest  input  ADDR_LEN  writeback address.
REQ-013 writeVal  input  WORD_LEN  writeback data.
REQ-014 flush  input  1  synchronous clear of all pending flags (pipeline flush).
REQ-015 anyBusy  output  1  OR of all pending flags (registered state, no bypass).

Function
REQ-016 Storage SHALL be DEPTH x WORD_LEN; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-017 Writeback: writeEn=1 and dest!=0 SHALL store writeVal into dest at the rising edge; write latency 1 cycle.
REQ-018 Reads SHALL be combinational from storage.
REQ-019 With BYPASS=1, reg1 SHALL equal writeVal when writeEn=1, dest==src1, src1!=0; same rule for reg2/src2.
REQ-020 With BYPASS=0, reads SHALL return pre-edge storage contents; new data visible the cycle after the write.
REQ-021 Scoreboard: one pending bit per register; bit 0 SHALL be constant 0.
REQ-022 issueEn=1, issueDest!=0 SHALL set pending[issueDest] at the edge.
REQ-023 writeEn=1, dest!=0 SHALL clear pending[dest] at the edge.
REQ-024 Simultaneous issue and writeback to the same register: pending SHALL end set (new producer wins).
REQ-025 Writeback to a register with pending=0 SHALL still write data; pending stays 0.
REQ-026 flush=1 SHALL clear every pending bit at the edge, overriding writeback clears; an issueEn in the same cycle SHALL be ignored; data writes in the same cycle SHALL still occur.
REQ-027 busy1 SHALL equal pending[src1], forced 0 when BYPASS=1 and a same-cycle writeback to src1 (src1!=0) is present; same for busy2.
REQ-028 Issue in the current cycle SHALL NOT affect busy1/busy2 until the next cycle.
REQ-029 anyBusy SHALL reflect registered pending bits only.

Reset
REQ-030 rst=0 SHALL asynchronously clear all registers to 0 and all pending bits to 0, including mid-operation.
REQ-031 While rst=0: reg1/reg2 SHALL read 0, busy1/busy2/anyBusy SHALL be 0, writes and issues ignored.
REQ-032 First write after rst deassertion SHALL be accepted at the first rising edge with rst=1.

Structure
REQ-033 Default WORD_LEN, ADDR_LEN, and zero-register index SHALL be constants in the shared defines package.
REQ-034 The scoreboard SHALL be one sub-module, reg_scoreboard (pending vector, set/clear/flush logic, busy lookups).
REQ-035 Storage and bypass muxes SHALL stay in reg_file_sb; no other sub-modules.

Verification
REQ-036 Reset: write 0xDEADBEEF to r5, assert rst=0 mid-cycle -> reg1 (src1=5) is 0 immediately, anyBusy=0.
REQ-037 Zero register: writeEn=1, dest=0, writeVal=0x1234 -> reg1 (src1=0) reads 0 same and next cycle.
REQ-038 Bypass: BYPASS=1, writeEn=1, dest=3, writeVal=0xA5A5A5A5, src1=3 -> reg1=0xA5A5A5A5 same cycle; BYPASS=0 -> old value, new value next cycle.
REQ-039 Scoreboard: issue r7; next cycle src2=7 -> busy2=1, anyBusy=1; writeback r7=0x42 -> busy2=0 same cycle (BYPASS=1), reg2=0x42.
REQ-040 Collision: issue r4 and writeback r4 same cycle -> next cycle busy1 (src1=4)=1, reg1=written value.
REQ-041 Flush: issue r2, r9, r12; flush=1 with issueEn for r6 -> next cycle anyBusy=0, busy for r6=0.
